// File: rtl/plugboard_config_ctrl.sv
// ---------------------------------------------------------------------------
// plugboard_config_ctrl
//
// Builds a plugboard letter-pair table behind a valid/ready handshake and
// publishes it atomically. Each pair is validated (range, self-pairing,
// table full, duplicate letter) before it enters the shadow table; a commit
// copies the whole shadow table into the active table that drives the
// plugboard slot inputs. Empty slots hold UNUSED_CODE, a value no letter can
// take, so the downstream lookup falls through to pass-through.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   pair_valid/pair_ready pair write handshake; pair_a/pair_b the letters
//   clear_req             empty the shadow table (answered via resp_valid)
//   commit_req            level request: copy shadow -> active
//   enc_busy              defers a pending commit while high
//   resp_valid/resp_err   one-cycle result pulse: 0 OK, 1 RANGE, 2 SELF,
//                         3 FULL, 4 DUP
//   commit_done           one-cycle pulse after the active table updates
//   pair_count            pairs held in the shadow table
//   pb_active             active slots, slot k at bits [6k+5:6k]
// ---------------------------------------------------------------------------
module plugboard_config_ctrl #(
    parameter int unsigned NUM_PAIRS   = 16,
    parameter int unsigned LETTERS     = 26,
    parameter logic [5:0]  UNUSED_CODE = 6'h3F
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pair_valid,
    output logic                   pair_ready,
    input  logic [5:0]             pair_a,
    input  logic [5:0]             pair_b,
    input  logic                   clear_req,
    input  logic                   commit_req,
    input  logic                   enc_busy,
    output logic                   resp_valid,
    output logic [2:0]             resp_err,
    output logic                   commit_done,
    output logic [4:0]             pair_count,
    output logic [12*NUM_PAIRS-1:0] pb_active
);

    localparam int unsigned SLOTS      = 2 * NUM_PAIRS;
    localparam int unsigned SW         = $clog2(SLOTS);
    localparam logic [5:0]  LETTER_LIM = 6'(LETTERS);
    localparam logic [4:0]  PAIR_MAX   = 5'(NUM_PAIRS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE
    } state_e;

    typedef enum logic [2:0] {
        ERR_OK    = 3'd0,
        ERR_RANGE = 3'd1,
        ERR_SELF  = 3'd2,
        ERR_FULL  = 3'd3,
        ERR_DUP   = 3'd4
    } err_e;

    state_e        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [4:0]    count_q, count_d;
    logic [5:0]    a_q, a_d;
    logic [5:0]    b_q, b_d;
    logic          resp_valid_q, resp_valid_d;
    err_e          resp_err_q, resp_err_d;
    logic          commit_done_q, commit_done_d;

    logic          clear_tbl;
    logic          write_tbl;
    logic          commit_tbl;

    logic [5:0]    shadow_q [SLOTS];
    logic [5:0]    active_q [SLOTS];

    logic [SW-1:0] scan_lo, scan_hi;
    logic [SW-1:0] wr_lo, wr_hi;
    logic          dup_hit;

    // Slot pair 2*i / 2*i+1 for the scan index and the write position.
    // When idx reaches NUM_PAIRS the truncated index wraps, but the scan
    // terminates on idx == count before dup_hit is consulted.
    assign scan_lo = {idx_q[SW-2:0], 1'b0};
    assign scan_hi = {idx_q[SW-2:0], 1'b1};
    assign wr_lo   = {count_q[SW-2:0], 1'b0};
    assign wr_hi   = {count_q[SW-2:0], 1'b1};

    assign dup_hit = (shadow_q[scan_lo] == a_q) || (shadow_q[scan_lo] == b_q) ||
                     (shadow_q[scan_hi] == a_q) || (shadow_q[scan_hi] == b_q);

    // The handshake must see clear/commit in the same cycle, so ready is
    // decoded from the registered state and the live request inputs.
    assign pair_ready = !reset && (state_q == S_IDLE) && !clear_req && !commit_req;

    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign commit_done = commit_done_q;
    assign pair_count  = count_q;

    always_comb begin
        pb_active = '0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            pb_active[6*k +: 6] = active_q[k];
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        count_d       = count_q;
        a_d           = a_q;
        b_d           = b_q;
        resp_valid_d  = 1'b0;
        resp_err_d    = ERR_OK;
        commit_done_d = 1'b0;
        clear_tbl     = 1'b0;
        write_tbl     = 1'b0;
        commit_tbl    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    clear_tbl    = 1'b1;
                    count_d      = '0;
                    resp_valid_d = 1'b1;
                end else if (commit_req) begin
                    if (!enc_busy) begin
                        commit_tbl    = 1'b1;
                        commit_done_d = 1'b1;
                    end
                end else if (pair_valid) begin
                    a_d   = pair_a;
                    b_d   = pair_b;
                    idx_d = '0;
                    if ((pair_a >= LETTER_LIM) || (pair_b >= LETTER_LIM)) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = ERR_RANGE;
                    end else if (pair_a == pair_b) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = ERR_SELF;
                    end else if (count_q == PAIR_MAX) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = ERR_FULL;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                if (idx_q == count_q) begin
                    state_d = S_WRITE;
                end else if (dup_hit) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_DUP;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end

            S_WRITE: begin
                write_tbl    = 1'b1;
                count_d      = count_q + 5'd1;
                state_d      = S_IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = ERR_OK;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            count_q       <= '0;
            a_q           <= '0;
            b_q           <= '0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= ERR_OK;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            a_q           <= a_d;
            b_q           <= b_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            commit_done_q <= commit_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '{default: UNUSED_CODE};
            active_q <= '{default: UNUSED_CODE};
        end else begin
            if (clear_tbl) begin
                shadow_q <= '{default: UNUSED_CODE};
            end
            if (write_tbl) begin
                shadow_q[wr_lo] <= a_q;
                shadow_q[wr_hi] <= b_q;
            end
            if (commit_tbl) begin
                active_q <= shadow_q;
            end
        end
    end

endmodule

// File: tb/tb_plugboard_config_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for plugboard_config_ctrl. Two instances share one stimulus stream:
// u0 with the default 26-letter alphabet and u1 with 32 letters (so all 16
// pairs can be filled with disjoint letters). A pair-list model predicts every
// output of both instances each cycle; directed sections add literal checks.
// ---------------------------------------------------------------------------
module tb_plugboard_config_ctrl;

    localparam int NP  = 16;
    localparam int SL  = 2 * NP;
    localparam int PBW = 12 * NP;

    logic clk;
    logic reset, pair_valid, clear_req, commit_req, enc_busy;
    logic [5:0] pair_a, pair_b;

    logic u0_pr, u0_rv, u0_cd, u1_pr, u1_rv, u1_cd;
    logic [2:0] u0_re, u1_re;
    logic [4:0] u0_pc, u1_pc;
    logic [PBW-1:0] u0_pb, u1_pb;

    logic pr [2];
    logic rv [2];
    logic cd [2];
    logic [2:0] re [2];
    logic [4:0] pc [2];
    logic [PBW-1:0] pb [2];

    assign pr[0] = u0_pr; assign pr[1] = u1_pr;
    assign rv[0] = u0_rv; assign rv[1] = u1_rv;
    assign cd[0] = u0_cd; assign cd[1] = u1_cd;
    assign re[0] = u0_re; assign re[1] = u1_re;
    assign pc[0] = u0_pc; assign pc[1] = u1_pc;
    assign pb[0] = u0_pb; assign pb[1] = u1_pb;

    plugboard_config_ctrl u0 (
        .clk(clk), .reset(reset), .pair_valid(pair_valid), .pair_ready(u0_pr),
        .pair_a(pair_a), .pair_b(pair_b), .clear_req(clear_req),
        .commit_req(commit_req), .enc_busy(enc_busy), .resp_valid(u0_rv),
        .resp_err(u0_re), .commit_done(u0_cd), .pair_count(u0_pc),
        .pb_active(u0_pb)
    );

    plugboard_config_ctrl #(.LETTERS(32)) u1 (
        .clk(clk), .reset(reset), .pair_valid(pair_valid), .pair_ready(u1_pr),
        .pair_a(pair_a), .pair_b(pair_b), .clear_req(clear_req),
        .commit_req(commit_req), .enc_busy(enc_busy), .resp_valid(u1_rv),
        .resp_err(u1_re), .commit_done(u1_cd), .pair_count(u1_pc),
        .pb_active(u1_pb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [PBW-1:0] act, input logic [PBW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: stored pair list per instance -----
    int         m_busy [2];   // cycles until the instance is back in IDLE
    int         m_cnt  [2];
    logic [5:0] m_sa   [2][NP];
    logic [5:0] m_sb   [2][NP];
    logic [5:0] m_act  [2][SL];
    logic       m_rv   [2];
    logic       m_cd   [2];
    logic [2:0] m_re   [2];
    logic [2:0] m_pcode[2];
    logic [5:0] m_pa   [2];
    logic [5:0] m_pb   [2];
    bit         started = 1'b0;

    function automatic int letters_of(input int i);
        return (i == 0) ? 26 : 32;
    endfunction

    function automatic bit model_ready(input int i);
        return !reset && (m_busy[i] == 0) && !clear_req && !commit_req;
    endfunction

    function automatic logic [PBW-1:0] exp_pb(input int i);
        logic [PBW-1:0] v;
        for (int k = 0; k < SL; k++) v[6*k +: 6] = m_act[i][k];
        return v;
    endfunction

    function automatic void model_step(input int i);
        int dupj;
        m_rv[i] = 1'b0;
        m_re[i] = 3'd0;
        m_cd[i] = 1'b0;
        if (reset) begin
            m_busy[i] = 0;
            m_cnt[i]  = 0;
            for (int k = 0; k < SL; k++) m_act[i][k] = 6'h3F;
        end else if (m_busy[i] > 0) begin
            m_busy[i]--;
            if (m_busy[i] == 0) begin
                m_rv[i] = 1'b1;
                m_re[i] = m_pcode[i];
                if (m_pcode[i] == 3'd0) begin
                    m_sa[i][m_cnt[i]] = m_pa[i];
                    m_sb[i][m_cnt[i]] = m_pb[i];
                    m_cnt[i]++;
                end
            end
        end else if (clear_req) begin
            m_cnt[i] = 0;
            m_rv[i]  = 1'b1;
        end else if (commit_req) begin
            if (!enc_busy) begin
                for (int k = 0; k < NP; k++) begin
                    m_act[i][2*k]   = (k < m_cnt[i]) ? m_sa[i][k] : 6'h3F;
                    m_act[i][2*k+1] = (k < m_cnt[i]) ? m_sb[i][k] : 6'h3F;
                end
                m_cd[i] = 1'b1;
            end
        end else if (pair_valid) begin
            if (int'(pair_a) >= letters_of(i) || int'(pair_b) >= letters_of(i)) begin
                m_rv[i] = 1'b1; m_re[i] = 3'd1;
            end else if (pair_a == pair_b) begin
                m_rv[i] = 1'b1; m_re[i] = 3'd2;
            end else if (m_cnt[i] == NP) begin
                m_rv[i] = 1'b1; m_re[i] = 3'd3;
            end else begin
                dupj = -1;
                for (int k = 0; k < m_cnt[i]; k++) begin
                    if (dupj < 0 && (m_sa[i][k] == pair_a || m_sa[i][k] == pair_b ||
                                     m_sb[i][k] == pair_a || m_sb[i][k] == pair_b))
                        dupj = k;
                end
                m_pa[i] = pair_a;
                m_pb[i] = pair_b;
                if (dupj >= 0) begin
                    m_busy[i]  = dupj + 1;        // DUP seen while scanning pair j
                    m_pcode[i] = 3'd4;
                end else begin
                    m_busy[i]  = m_cnt[i] + 2;    // n+1 scan cycles, then the write
                    m_pcode[i] = 3'd0;
                end
            end
        end
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d.pair_ready", i), int'(pr[i]), int'(model_ready(i)));
                chk($sformatf("u%0d.resp_valid", i), int'(rv[i]), int'(m_rv[i]));
                chk($sformatf("u%0d.resp_err", i), int'(re[i]), int'(m_re[i]));
                chk($sformatf("u%0d.commit_done", i), int'(cd[i]), int'(m_cd[i]));
                chk($sformatf("u%0d.pair_count", i), int'(pc[i]), m_cnt[i]);
                chkv($sformatf("u%0d.pb_active", i), pb[i], exp_pb(i));
            end
        end
    end

    // ---------------- directed helpers ------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(pr[0] && pr[1]) && n < 60) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", int'(pr[0] && pr[1]), 1);
    endtask

    // Offer one pair and report the result seen on instance sel; lat is the
    // edge count from accept to the edge that samples resp_valid high.
    task automatic do_pair(input int sel, input int a, input int b,
                           output int err, output int lat);
        wait_idle();
        pair_valid = 1'b1;
        pair_a     = 6'(a);
        pair_b     = 6'(b);
        chk("ready_at_offer", int'(pr[sel]), 1);
        tick();
        pair_valid = 1'b0;
        lat = -1;
        err = -1;
        for (int e = 0; e < 60; e++) begin
            if (rv[sel]) begin
                lat = e + 1;
                err = int'(re[sel]);
                break;
            end
            tick();
        end
        chk("resp_timeout", int'(lat > 0), 1);
    endtask

    task automatic commit_pulse();
        wait_idle();
        commit_req = 1'b1;
        enc_busy   = 1'b0;
        tick();
        commit_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int err, lat, n;
        logic [PBW-1:0] v, save;

        reset = 1'b1; pair_valid = 1'b0; clear_req = 1'b0;
        commit_req = 1'b0; enc_busy = 1'b0; pair_a = '0; pair_b = '0;

        // Reset state
        tick(); tick();
        chk("reset_ready", int'(pr[0]), 0);
        chk("reset_resp_valid", int'(rv[0]), 0);
        chk("reset_count", int'(pc[0]), 0);
        chkv("reset_pb", pb[0], '1);
        reset = 1'b0;
        tick();

        // First pair, then commit
        do_pair(0, 0, 1, err, lat);
        chk("p01_err", err, 0);
        chk("p01_lat", lat, 3);
        chk("p01_count", int'(pc[0]), 1);
        chkv("p01_pb_precommit", pb[0], '1);
        commit_pulse();
        chk("commit1_done", int'(cd[0]), 1);
        v = pb[0];
        chk("commit1_slot0", int'(v[5:0]), 0);
        chk("commit1_slot1", int'(v[11:6]), 1);
        chk("commit1_rest", int'(&v[PBW-1:12]), 1);

        // Duplicate found at stored index 1
        do_pair(0, 2, 3, err, lat);
        chk("p23_err", err, 0);
        chk("p23_lat", lat, 4);
        do_pair(0, 3, 7, err, lat);
        chk("dup_err", err, 4);
        chk("dup_lat", lat, 3);
        chk("dup_count", int'(pc[0]), 2);
        commit_pulse();
        v = pb[0];
        chk("commit2_slots0_3", int'(v[23:0]), 'h0C2040);
        chk("commit2_slots4_5", int'(v[35:24]), 'hFFF);

        // Immediate errors
        do_pair(0, 26, 4, err, lat);
        chk("range_err", err, 1);
        chk("range_lat", lat, 1);
        do_pair(0, 5, 5, err, lat);
        chk("self_err", err, 2);
        chk("self_lat", lat, 1);
        chk("err_count", int'(pc[0]), 2);

        // Commit deferred by enc_busy; pair writes stall meanwhile
        wait_idle();
        save = pb[0];
        commit_req = 1'b1; enc_busy = 1'b1;
        pair_valid = 1'b1; pair_a = 6'd8; pair_b = 6'd9;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("busy_ready", int'(pr[0]), 0);
            chk("busy_no_done", int'(cd[0]), 0);
            chkv("busy_pb_hold", pb[0], save);
        end
        enc_busy = 1'b0;
        tick();
        commit_req = 1'b0; pair_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            if (cd[0]) n++;
            tick();
        end
        chk("busy_done_pulses", n, 1);
        chk("busy_count", int'(pc[0]), 2);

        // Reset during the duplicate scan
        do_pair(0, 10, 11, err, lat);
        chk("p1011_err", err, 0);
        chk("p1011_lat", lat, 5);
        chk("p1011_count", int'(pc[0]), 3);
        wait_idle();
        pair_valid = 1'b1; pair_a = 6'd4; pair_b = 6'd9;
        tick();
        pair_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (rv[0]) n++;
            tick();
        end
        chk("midreset_no_resp", n, 0);
        chk("midreset_count", int'(pc[0]), 0);
        chkv("midreset_pb", pb[0], '1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("clear_resp", int'(rv[0]), 1);
        chk("clear_err", int'(re[0]), 0);

        // Fill all 16 pairs on the 32-letter instance, then overflow
        for (int k = 0; k < NP; k++) begin
            do_pair(1, 2*k, 2*k+1, err, lat);
            chk($sformatf("fill%0d_err", k), err, 0);
            chk($sformatf("fill%0d_lat", k), lat, k + 3);
        end
        do_pair(1, 0, 1, err, lat);
        chk("full_err", err, 3);
        chk("full_lat", lat, 1);
        chk("full_count", int'(pc[1]), 16);
        commit_pulse();
        for (int k = 0; k < SL; k++) v[6*k +: 6] = 6'(k);
        chkv("full_pb", pb[1], v);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            reset      = ($urandom_range(0, 399) == 0);
            pair_valid = 1'($urandom_range(0, 1));
            pair_a     = 6'($urandom_range(0, 33));
            pair_b     = 6'($urandom_range(0, 33));
            clear_req  = ($urandom_range(0, 39) == 0);
            commit_req = ($urandom_range(0, 9) == 0);
            enc_busy   = ($urandom_range(0, 2) == 0);
            tick();
        end
        reset = 1'b0; pair_valid = 1'b0; clear_req = 1'b0;
        commit_req = 1'b0; enc_busy = 1'b0;
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
